// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding, default sizes and drain length helper for the systolic feeder
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } feeder_state_t;

    localparam int DEFAULT_MATRIX_SIZE = 2;
    localparam int DEFAULT_DATA_SIZE   = 32;

    // Zeros must flow until the last lane's final operand has crossed the whole array.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH+1 stage register shift chain, one per feeder lane
module skew_delay_line #(
    parameter int DEPTH     = 0,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] dout
);

    logic [DATA_SIZE-1:0] stage [DEPTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i <= DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - loads weight rows, streams skewed activation rows, drains and pulses done; SYSTOLIC_FEEDER_PERF_EN adds bubble_count
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_SIZE-1:0] w_row       [MATRIX_SIZE-1:0],
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [DATA_SIZE-1:0] a_row       [MATRIX_SIZE-1:0],
    input  logic                 a_last,
    output logic                 ld_weight,
    output logic [DATA_SIZE-1:0] out_weights [MATRIX_SIZE-1:0],
    output logic [DATA_SIZE-1:0] out_data    [MATRIX_SIZE-1:0],
    output logic                 busy,
    output logic                 done
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [15:0]          bubble_count
`endif
);

    localparam int CW = $clog2(2 * MATRIX_SIZE) + 1;
    localparam logic [CW-1:0] W_LAST     = CW'(MATRIX_SIZE);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cycles(MATRIX_SIZE) - 1);

    feeder_state_t state, state_n;
    logic [CW-1:0] wcnt, dcnt;
    logic [CW-1:0] wcnt_inc;
    logic          w_acc, a_acc;

    assign wcnt_inc = wcnt + CW'(1);
    assign w_acc    = w_valid && w_ready;
    assign a_acc    = a_valid && a_ready;

    always_comb begin
        state_n = state;
        w_ready = 1'b0;
        a_ready = 1'b0;
        case (state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_valid) state_n = (MATRIX_SIZE == 1) ? STREAM : LOAD_W;
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (wcnt_inc == W_LAST)) state_n = STREAM;
            end
            STREAM: begin
                a_ready = 1'b1;
                if (a_valid && a_last) state_n = DRAIN;
            end
            DRAIN: begin
                if (dcnt == DRAIN_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            dcnt      <= '0;
            ld_weight <= 1'b0;
            for (int k = 0; k < MATRIX_SIZE; k++) begin
                out_weights[k] <= '0;
            end
        end else begin
            state     <= state_n;
            ld_weight <= w_acc;
            if (w_acc) begin
                wcnt <= (state == IDLE) ? CW'(1) : wcnt_inc;
                for (int k = 0; k < MATRIX_SIZE; k++) begin
                    out_weights[k] <= w_row[k];
                end
            end
            // dcnt indexes the current DRAIN cycle, so it restarts at zero on entry.
            dcnt <= (state == DRAIN) ? dcnt + CW'(1) : '0;
        end
    end

    // Lane k sits behind k extra registers so operands reach the right PE diagonal.
    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        logic [DATA_SIZE-1:0] lane_in;
        assign lane_in = a_acc ? a_row[k] : '0;
        skew_delay_line #(
            .DEPTH     (k),
            .DATA_SIZE (DATA_SIZE)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .din   (lane_in),
            .dout  (out_data[k])
        );
    end

    assign busy = (state != IDLE);
    // Gated by reset so a job abandoned on its final drain cycle never reports done.
    assign done = (state == DRAIN) && (dcnt == DRAIN_LAST) && !reset;

`ifdef SYSTOLIC_FEEDER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (state == IDLE && w_acc) begin
            bubble_count <= '0;
        end else if (state == STREAM && !a_valid && bubble_count != 16'hFFFF) begin
            bubble_count <= bubble_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;

    localparam int MS = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [DW-1:0] w_row [MS-1:0];
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] a_row [MS-1:0];
    logic          a_last = 1'b0;
    logic          ld_weight;
    logic [DW-1:0] out_weights [MS-1:0];
    logic [DW-1:0] out_data [MS-1:0];
    logic          busy;
    logic          done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0]   bubble_count;
`endif

    int total = 0;
    int bad   = 0;

    systolic_feeder #(.MATRIX_SIZE(MS), .DATA_SIZE(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_row       (w_row),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_row       (a_row),
        .a_last      (a_last),
        .ld_weight   (ld_weight),
        .out_weights (out_weights),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
        ,
        .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int r0, input int r1);
        w_row[0] = r0;
        w_row[1] = r1;
    endtask

    task automatic set_a(input int r0, input int r1);
        a_row[0] = r0;
        a_row[1] = r1;
    endtask

    task automatic check_data(input string tag, input int e0, input int e1);
        check({tag, "_lane0"}, out_data[0], e0);
        check({tag, "_lane1"}, out_data[1], e1);
    endtask

    initial begin
        set_w(0, 0);
        set_a(0, 0);
        step();
        step();
        reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_w_ready", w_ready, 1);
        check("rst_a_ready", a_ready, 0);
        check("rst_ld_weight", ld_weight, 0);
        check("rst_done", done, 0);
        check("rst_w0", out_weights[0], 0);
        check("rst_w1", out_weights[1], 0);
        check_data("rst_data", 0, 0);

        // activation request in IDLE is ignored
        a_valid = 1'b1;
        set_a(55, 66);
        step();
        check("idle_a_busy", busy, 0);
        check_data("idle_a_data", 0, 0);
        check("idle_a_ld", ld_weight, 0);

        // weight load, activation request still asserted and ignored
        w_valid = 1'b1;
        set_w(1, 2);
        step();
        check("wl1_ld", ld_weight, 1);
        check("wl1_w0", out_weights[0], 1);
        check("wl1_w1", out_weights[1], 2);
        check("wl1_busy", busy, 1);
        check("wl1_w_ready", w_ready, 1);
        check("wl1_a_ready", a_ready, 0);
        check_data("wl1_data", 0, 0);
        set_w(3, 4);
        step();
        check("wl2_ld", ld_weight, 1);
        check("wl2_w0", out_weights[0], 3);
        check("wl2_w1", out_weights[1], 4);
        check("wl2_w_ready", w_ready, 0);
        check("wl2_a_ready", a_ready, 1);

        // weight request during STREAM is ignored, weights hold
        a_valid = 1'b0;
        set_w(9, 9);
        step();
        check("st_w_ld", ld_weight, 0);
        check("st_w_w0", out_weights[0], 3);
        check("st_w_w1", out_weights[1], 4);
        check_data("st_w_data", 0, 0);
        w_valid = 1'b0;

        // skew: [5,6] then [7,8] with a_last
        a_valid = 1'b1;
        set_a(5, 6);
        step();
        check_data("sk_t11", 5, 0);
        check("sk_t11_a_ready", a_ready, 1);
        set_a(7, 8);
        a_last = 1'b1;
        step();
        check_data("sk_t12", 7, 6);
        check("dr_t12_a_ready", a_ready, 0);
        check("dr_t12_w_ready", w_ready, 0);
        check("dr_t12_busy", busy, 1);
        check("dr_t12_done", done, 0);
        a_valid = 1'b0;
        a_last = 1'b0;
        step();
        check_data("sk_t13", 0, 8);
        check("dr_t13_done", done, 0);
        check("dr_t13_a_ready", a_ready, 0);
        step();
        check_data("sk_t14", 0, 0);
        check("dr_t14_done", done, 1);
        check("dr_t14_busy", busy, 1);
        step();
        check("dr_t15_busy", busy, 0);
        check("dr_t15_done", done, 0);
        check("dr_t15_w_ready", w_ready, 1);

        // bubbles: pattern 1,0,1
        w_valid = 1'b1;
        set_w(10, 20);
        step();
        set_w(30, 40);
        step();
        w_valid = 1'b0;
        check("bb_a_ready", a_ready, 1);
        a_valid = 1'b1;
        set_a(1, 1);
        step();
        check_data("bb_c1", 1, 0);
        a_valid = 1'b0;
        set_a(77, 77);
        step();
        check_data("bb_c2", 0, 1);
        a_valid = 1'b1;
        a_last = 1'b1;
        set_a(2, 2);
        step();
        check_data("bb_c3", 2, 0);
        a_valid = 1'b0;
        a_last = 1'b0;
        step();
        check_data("bb_c4", 0, 2);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("bb_count", bubble_count, 1);
`endif
        check("bb_c4_done", done, 0);
        step();
        check("bb_c5_done", done, 1);
        step();
        check("bb_idle_busy", busy, 0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
        check("bb_count_hold", bubble_count, 1);
`endif

        // reset mid-STREAM
        w_valid = 1'b1;
        set_w(5, 5);
        step();
        step();
        w_valid = 1'b0;
        a_valid = 1'b1;
        set_a(9, 9);
        step();
        check_data("rs_acc", 9, 0);
        a_valid = 1'b0;
        reset = 1'b1;
        step();
        check_data("rs_after", 0, 0);
        check("rs_busy", busy, 0);
        check("rs_w_ready", w_ready, 1);
        check("rs_done", done, 0);
        check("rs_ld", ld_weight, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rs_no_done", done, 0);
            check("rs_idle", busy, 0);
            check_data("rs_quiet", 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
